// File: rtl/pong_frame_ctrl_if.sv
// Interface between the BASPONG game controller and its neighbours:
// frame timing and button inputs in, game positions/scores/state out.
interface pong_frame_ctrl_if;
  logic       vertical_scan;
  logic       start;
  logic       l_up;
  logic       l_down;
  logic       r_up;
  logic       r_down;
  logic       frame_tick;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] paddle_l_y;
  logic [9:0] paddle_r_y;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [2:0] game_state;

  // Driver side: sync generator / buttons / renderer.
  modport master (
    output vertical_scan, start, l_up, l_down, r_up, r_down,
    input  frame_tick, ball_x, ball_y, paddle_l_y, paddle_r_y,
           score_l, score_r, game_state
  );

  // Controller side.
  modport slave (
    input  vertical_scan, start, l_up, l_down, r_up, r_down,
    output frame_tick, ball_x, ball_y, paddle_l_y, paddle_r_y,
           score_l, score_r, game_state
  );
endinterface

// File: rtl/pong_frame_ctrl.sv
// BASPONG per-frame game controller. A one-cycle frame tick is derived from
// the falling edge of vertical_scan; ball, paddles, scores and match state
// change only on the edge where that tick is high, so the renderer sees
// stable registers during active video.
module pong_frame_ctrl #(
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned BALL_SIZE    = 8,
  parameter int unsigned PADDLE_W     = 8,
  parameter int unsigned PADDLE_H     = 64,
  parameter int unsigned PADDLE_XL    = 16,
  parameter int unsigned PADDLE_XR    = 616,
  parameter int unsigned BALL_SPEED   = 2,
  parameter int unsigned PADDLE_SPEED = 4,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 5
) (
  input  logic            clk,
  input  logic            reset,
  pong_frame_ctrl_if.slave pf_if
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  // 11-bit geometry so sums never wrap.
  localparam logic [10:0] SW     = 11'(SCREEN_W);
  localparam logic [10:0] SH     = 11'(SCREEN_H);
  localparam logic [10:0] BSZ    = 11'(BALL_SIZE);
  localparam logic [10:0] PH     = 11'(PADDLE_H);
  localparam logic [10:0] XR     = 11'(PADDLE_XR);
  localparam logic [10:0] LFACE  = 11'(PADDLE_XL + PADDLE_W);
  localparam logic [10:0] BSP    = 11'(BALL_SPEED);
  localparam logic [10:0] PSP    = 11'(PADDLE_SPEED);
  localparam logic [10:0] PMAX   = 11'(SCREEN_H - PADDLE_H);

  // 10-bit values loaded straight into position registers.
  localparam logic [9:0]  CX       = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  CY       = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0]  PINIT    = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [9:0]  BOT10    = 10'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0]  LFACE10  = 10'(PADDLE_XL + PADDLE_W);
  localparam logic [9:0]  RCLAMP10 = 10'(PADDLE_XR - BALL_SIZE);
  localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0]  WIN      = 4'(WIN_SCORE);

  // Saturating paddle move: one button moves, both or none hold.
  function automatic logic [9:0] paddle_step(input logic [9:0] y,
                                             input logic up, input logic dn);
    logic [10:0] yw;
    yw = {1'b0, y};
    if (up && !dn) begin
      if (yw < PSP) return 10'd0;
      else          return 10'(yw - PSP);
    end else if (dn && !up) begin
      if (yw + PSP > PMAX) return 10'(PMAX);
      else                 return 10'(yw + PSP);
    end else begin
      return y;
    end
  endfunction

  logic       vs_d_q;
  logic       frame_tick_q;
  logic [2:0] state_q,   state_d;
  logic [9:0] ball_x_q,  ball_x_d;
  logic [9:0] ball_y_q,  ball_y_d;
  logic [9:0] pl_q,      pl_d;
  logic [9:0] pr_q,      pr_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic       dx_pos_q,  dx_pos_d;
  logic       dy_pos_q,  dy_pos_d;
  logic [7:0] serve_cnt_q, serve_cnt_d;
  logic       point_left_q, point_left_d;

  logic [10:0] bx_w, by_w, pl_w, pr_w;
  logic [9:0]  by_n;
  logic        dy_n;
  logic        l_hit, r_hit, miss_l, miss_r;
  logic [3:0]  score_l_inc, score_r_inc;

  assign bx_w = {1'b0, ball_x_q};
  assign by_w = {1'b0, ball_y_q};
  assign pl_w = {1'b0, pl_q};
  assign pr_w = {1'b0, pr_q};

  // Hit and miss tests read the current (pre-update) ball and paddle registers.
  assign l_hit  = ~dx_pos_q && (bx_w >= LFACE) && (bx_w < LFACE + BSP) &&
                  (by_w + BSZ > pl_w) && (by_w < pl_w + PH);
  assign r_hit  = dx_pos_q && (bx_w + BSZ <= XR) && (bx_w + BSZ + BSP > XR) &&
                  (by_w + BSZ > pr_w) && (by_w < pr_w + PH);
  assign miss_r = ~dx_pos_q && (bx_w < BSP);
  assign miss_l = dx_pos_q && (bx_w + BSZ + BSP > SW);

  assign score_l_inc = score_l_q + 4'd1;
  assign score_r_inc = score_r_q + 4'd1;

  // Candidate vertical ball position with top/bottom wall bounce.
  always_comb begin
    by_n = ball_y_q;
    dy_n = dy_pos_q;
    if (~dy_pos_q && (by_w < BSP)) begin
      by_n = 10'd0;
      dy_n = 1'b1;
    end else if (dy_pos_q && (by_w + BSZ + BSP > SH)) begin
      by_n = BOT10;
      dy_n = 1'b0;
    end else if (dy_pos_q) begin
      by_n = 10'(by_w + BSP);
    end else begin
      by_n = 10'(by_w - BSP);
    end
  end

  // Game state update, evaluated only for the frame-tick edge.
  always_comb begin
    state_d      = state_q;
    ball_x_d     = ball_x_q;
    ball_y_d     = ball_y_q;
    pl_d         = pl_q;
    pr_d         = pr_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    dx_pos_d     = dx_pos_q;
    dy_pos_d     = dy_pos_q;
    serve_cnt_d  = serve_cnt_q;
    point_left_d = point_left_q;
    if (frame_tick_q) begin
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (pf_if.start) begin
            state_d   = ST_SERVE;
            score_l_d = 4'd0;
            score_r_d = 4'd0;
            ball_x_d  = CX;
            ball_y_d  = CY;
          end else begin
            state_d = state_q;
          end
        end
        ST_SERVE: begin
          pl_d = paddle_step(pl_q, pf_if.l_up, pf_if.l_down);
          pr_d = paddle_step(pr_q, pf_if.r_up, pf_if.r_down);
          if (serve_cnt_q == SERVE_LAST) begin
            state_d     = ST_PLAY;
            serve_cnt_d = 8'd0;
          end else begin
            serve_cnt_d = serve_cnt_q + 8'd1;
          end
        end
        ST_PLAY: begin
          pl_d = paddle_step(pl_q, pf_if.l_up, pf_if.l_down);
          pr_d = paddle_step(pr_q, pf_if.r_up, pf_if.r_down);
          if (l_hit) begin
            ball_x_d = LFACE10;
            dx_pos_d = 1'b1;
            ball_y_d = by_n;
            dy_pos_d = dy_n;
          end else if (r_hit) begin
            ball_x_d = RCLAMP10;
            dx_pos_d = 1'b0;
            ball_y_d = by_n;
            dy_pos_d = dy_n;
          end else if (miss_r || miss_l) begin
            // Ball stays exactly where it missed until the point is scored.
            state_d      = ST_POINT;
            point_left_d = miss_l;
          end else begin
            ball_x_d = dx_pos_q ? 10'(bx_w + BSP) : 10'(bx_w - BSP);
            ball_y_d = by_n;
            dy_pos_d = dy_n;
          end
        end
        ST_POINT: begin
          if (point_left_q) begin
            score_l_d = score_l_inc;
          end else begin
            score_r_d = score_r_inc;
          end
          if ((point_left_q ? score_l_inc : score_r_inc) == WIN) begin
            state_d = ST_OVER;
          end else begin
            // Serve toward the player who conceded.
            state_d  = ST_SERVE;
            ball_x_d = CX;
            ball_y_d = CY;
            dx_pos_d = point_left_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Frame tick: registered falling-edge detect of vertical_scan.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_d_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      vs_d_q       <= pf_if.vertical_scan;
      frame_tick_q <= vs_d_q & ~pf_if.vertical_scan;
    end
  end

  // Game registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ball_x_q     <= CX;
      ball_y_q     <= CY;
      pl_q         <= PINIT;
      pr_q         <= PINIT;
      score_l_q    <= 4'd0;
      score_r_q    <= 4'd0;
      dx_pos_q     <= 1'b1;
      dy_pos_q     <= 1'b1;
      serve_cnt_q  <= 8'd0;
      point_left_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      pl_q         <= pl_d;
      pr_q         <= pr_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      dx_pos_q     <= dx_pos_d;
      dy_pos_q     <= dy_pos_d;
      serve_cnt_q  <= serve_cnt_d;
      point_left_q <= point_left_d;
    end
  end

  assign pf_if.frame_tick = frame_tick_q;
  assign pf_if.ball_x     = ball_x_q;
  assign pf_if.ball_y     = ball_y_q;
  assign pf_if.paddle_l_y = pl_q;
  assign pf_if.paddle_r_y = pr_q;
  assign pf_if.score_l    = score_l_q;
  assign pf_if.score_r    = score_r_q;
  assign pf_if.game_state = state_q;

endmodule

// File: tb/tb_pong_frame_ctrl.sv
// Bench for pong_frame_ctrl: each frame pushes the expected post-tick game
// snapshot into a queue; a monitor pops and compares after every frame tick.
// Hand-computed checkpoints cover reset, serve timing, clamps, scoring and
// reset during a tick.
module tb_pong_frame_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pong_frame_ctrl_if bus();
  pong_frame_ctrl dut (.clk(clk), .reset(reset), .pf_if(bus));

  typedef struct {
    int st; int bx; int by; int pl; int pr; int sl; int sr;
  } snap_t;
  snap_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // Reference game model.
  int m_st, m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_cnt;
  bit m_dxp, m_dyp, m_ptl;

  function automatic void model_reset();
    m_st = 0; m_bx = 316; m_by = 236; m_pl = 208; m_pr = 208;
    m_sl = 0; m_sr = 0; m_cnt = 0; m_dxp = 1'b1; m_dyp = 1'b1; m_ptl = 1'b0;
  endfunction

  function automatic int pad(int y, bit up, bit dn);
    if (up && !dn)      return (y < 4) ? 0 : y - 4;
    else if (dn && !up) return (y + 4 > 416) ? 416 : y + 4;
    else                return y;
  endfunction

  function automatic void model_step(bit s, bit lu, bit ld, bit ru, bit rd);
    int ny; bit ndy;
    case (m_st)
      0, 4: if (s) begin
        m_st = 1; m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236;
      end
      1: begin
        m_pl = pad(m_pl, lu, ld); m_pr = pad(m_pr, ru, rd);
        if (m_cnt == 59) begin m_st = 2; m_cnt = 0; end
        else m_cnt = m_cnt + 1;
      end
      2: begin
        if (!m_dyp && m_by < 2) begin ny = 0; ndy = 1'b1; end
        else if (m_dyp && m_by + 10 > 480) begin ny = 472; ndy = 1'b0; end
        else begin ny = m_by + (m_dyp ? 2 : -2); ndy = m_dyp; end
        if (!m_dxp && m_bx >= 24 && m_bx - 2 < 24 && m_by + 8 > m_pl && m_by < m_pl + 64) begin
          m_bx = 24; m_dxp = 1'b1; m_by = ny; m_dyp = ndy;
        end else if (m_dxp && m_bx + 8 <= 616 && m_bx + 10 > 616 && m_by + 8 > m_pr && m_by < m_pr + 64) begin
          m_bx = 608; m_dxp = 1'b0; m_by = ny; m_dyp = ndy;
        end else if (!m_dxp && m_bx < 2) begin
          m_st = 3; m_ptl = 1'b0;
        end else if (m_dxp && m_bx + 10 > 640) begin
          m_st = 3; m_ptl = 1'b1;
        end else begin
          m_bx = m_bx + (m_dxp ? 2 : -2); m_by = ny; m_dyp = ndy;
        end
        m_pl = pad(m_pl, lu, ld); m_pr = pad(m_pr, ru, rd);
      end
      3: begin
        if (m_ptl) m_sl = m_sl + 1; else m_sr = m_sr + 1;
        if ((m_ptl ? m_sl : m_sr) == 5) m_st = 4;
        else begin m_bx = 316; m_by = 236; m_dxp = m_ptl; m_st = 1; end
      end
      default: ;
    endcase
  endfunction

  task automatic chk(string name, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor: after each frame tick, compare the updated outputs with the queue head.
  initial begin
    snap_t e;
    forever begin
      @(negedge clk);
      if (mon_en && bus.frame_tick === 1'b1) begin
        @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_tick: state %0d, expected no tick", bus.game_state);
        end else begin
          e = exp_q.pop_front();
          if (bus.game_state != 3'(e.st) || bus.ball_x != 10'(e.bx) || bus.ball_y != 10'(e.by) ||
              bus.paddle_l_y != 10'(e.pl) || bus.paddle_r_y != 10'(e.pr) ||
              bus.score_l != 4'(e.sl) || bus.score_r != 4'(e.sr)) begin
            n_fail++;
            $display("FAIL frame_snapshot: got st=%0d bx=%0d by=%0d pl=%0d pr=%0d sl=%0d sr=%0d, expected st=%0d bx=%0d by=%0d pl=%0d pr=%0d sl=%0d sr=%0d",
                     bus.game_state, bus.ball_x, bus.ball_y, bus.paddle_l_y, bus.paddle_r_y,
                     bus.score_l, bus.score_r, e.st, e.bx, e.by, e.pl, e.pr, e.sl, e.sr);
          end
        end
      end
    end
  end

  task automatic frame(bit s, bit lu, bit ld, bit ru, bit rd);
    bus.start = s; bus.l_up = lu; bus.l_down = ld; bus.r_up = ru; bus.r_down = rd;
    model_step(s, lu, ld, ru, rd);
    exp_q.push_back('{m_st, m_bx, m_by, m_pl, m_pr, m_sl, m_sr});
    @(negedge clk) bus.vertical_scan = 1'b0;
    @(negedge clk) chk("tick_high", int'(bus.frame_tick), 1);
    @(negedge clk) chk("tick_one_cycle", int'(bus.frame_tick), 0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("scoreboard_drain", exp_q.size(), 0);
      exp_q.delete();
    end
    bus.vertical_scan = 1'b1;
    @(negedge clk);
  endtask

  // Paddle steering from the model ball: track = follow, else move away.
  function automatic bit [1:0] trk(int py, int by);
    if (py + 32 < by + 2)      return 2'b01;
    else if (py + 32 > by + 6) return 2'b10;
    else                       return 2'b00;
  endfunction

  function automatic bit [1:0] avoid(int by);
    return (by < 240) ? 2'b01 : 2'b10;
  endfunction

  task automatic chk_reset_vals(string tag);
    chk({tag, "_state"}, int'(bus.game_state), 0);
    chk({tag, "_ball_x"}, int'(bus.ball_x), 316);
    chk({tag, "_ball_y"}, int'(bus.ball_y), 236);
    chk({tag, "_pad_l"}, int'(bus.paddle_l_y), 208);
    chk({tag, "_pad_r"}, int'(bus.paddle_r_y), 208);
    chk({tag, "_score_l"}, int'(bus.score_l), 0);
    chk({tag, "_score_r"}, int'(bus.score_r), 0);
    chk({tag, "_tick"}, int'(bus.frame_tick), 0);
  endtask

  initial begin
    bit [1:0] a, b;
    int saved_pl, saved_pr, saved_bx;
    bus.vertical_scan = 1'b1; bus.start = 1'b0;
    bus.l_up = 1'b0; bus.l_down = 1'b0; bus.r_up = 1'b0; bus.r_down = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");
    mon_en = 1'b1;

    // IDLE holds without start.
    repeat (3) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_hold", int'(bus.game_state), 0);

    // Start, then serve with left-up / right-down held to exercise clamps.
    frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("start_serve", int'(bus.game_state), 1);
    repeat (60) frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("serve_done_play", int'(bus.game_state), 2);
    chk("serve_ball_held", int'(bus.ball_x), 316);
    chk("clamp_left_top", int'(bus.paddle_l_y), 0);
    chk("clamp_right_bot", int'(bus.paddle_r_y), 416);

    // First PLAY tick moves the ball diagonally.
    frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("first_play_x", int'(bus.ball_x), 318);
    chk("first_play_y", int'(bus.ball_y), 238);

    // Rally: both paddles track the ball (paddle hits and wall bounces).
    repeat (700) begin
      a = trk(m_pl, m_by); b = trk(m_pr, m_by);
      frame(1'b0, a[1], a[0], b[1], b[0]);
    end

    // Left dodges until right scores.
    for (int i = 0; i < 2000 && m_sr == 0; i++) begin
      a = avoid(m_by); b = trk(m_pr, m_by);
      frame(1'b0, a[1], a[0], b[1], b[0]);
    end
    chk("right_scored", int'(bus.score_r), 1);
    chk("point_to_serve", int'(bus.game_state), 1);
    chk("point_centered", int'(bus.ball_x), 316);

    // Right dodges until left wins.
    for (int i = 0; i < 6000 && m_st != 4; i++) begin
      a = trk(m_pl, m_by); b = avoid(m_by);
      frame(1'b0, a[1], a[0], b[1], b[0]);
    end
    chk("left_wins_score", int'(bus.score_l), 5);
    chk("left_wins_over", int'(bus.game_state), 4);

    // OVER is frozen even with buttons pressed.
    saved_bx = m_bx; saved_pl = m_pl; saved_pr = m_pr;
    repeat (3) frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("over_ball_frozen", int'(bus.ball_x), saved_bx);
    chk("over_pad_frozen", int'(bus.paddle_l_y), saved_pl);

    // Restart from OVER.
    frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("restart_state", int'(bus.game_state), 1);
    chk("restart_score_l", int'(bus.score_l), 0);
    chk("restart_ball_y", int'(bus.ball_y), 236);

    // Both buttons on each side: no paddle motion.
    repeat (5) frame(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("both_hold_l", int'(bus.paddle_l_y), saved_pl);
    chk("both_hold_r", int'(bus.paddle_r_y), saved_pr);

    // Into PLAY, then reset while frame_tick is high.
    repeat (70) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid_play", int'(bus.game_state), 2);
    mon_en = 1'b0;
    @(negedge clk) bus.vertical_scan = 1'b0;
    @(negedge clk) chk("pre_reset_tick", int'(bus.frame_tick), 1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_reset");
    bus.vertical_scan = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
    mon_en = 1'b1;
    repeat (2) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_idle", int'(bus.game_state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
